// File: rtl/ts_capture_arbiter.sv
// Latches the shared seconds/nanoseconds timestamp per capture port and drains the held
// records round-robin into a single valid/ready stream, counting captures lost to busy slots.
module ts_capture_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DROP_CNT_W = 16,
  parameter int unsigned PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           i_ts_seconds,
  input  logic [31:0]           i_ts_nanoseconds,
  input  logic [NUM_PORTS-1:0]  i_cap_req,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [PORT_W-1:0]     o_out_port,
  output logic [31:0]           o_out_seconds,
  output logic [31:0]           o_out_nanoseconds,
  output logic [NUM_PORTS-1:0]  o_drop_flag,
  output logic [DROP_CNT_W-1:0] o_drop_count,
  input  logic                  i_drop_clear
);

  localparam int unsigned SumW = DROP_CNT_W + 5;

  logic [NUM_PORTS-1:0]  r_pending;
  logic [31:0]           r_slot_sec [NUM_PORTS];
  logic [31:0]           r_slot_ns  [NUM_PORTS];
  logic [PORT_W-1:0]     r_ptr;
  logic                  r_valid;
  logic [PORT_W-1:0]     r_port;
  logic [31:0]           r_sec;
  logic [31:0]           r_ns;
  logic [NUM_PORTS-1:0]  r_drop_flag;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_load;
  logic [PORT_W:0]       w_idx;
  logic [PORT_W-1:0]     w_grant;
  logic [PORT_W-1:0]     w_ptr_next;
  logic [NUM_PORTS-1:0]  w_move;
  logic [NUM_PORTS-1:0]  w_keep;
  logic [NUM_PORTS-1:0]  w_drop;
  logic [4:0]            w_ndrop;
  logic [SumW-1:0]       w_cnt_sum;
  logic [DROP_CNT_W-1:0] w_cnt_next;

  // Scan downwards so the last hit is the first pending port at or after the pointer.
  always_comb begin
    w_idx   = '0;
    w_grant = r_ptr;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + (PORT_W + 1)'(i);
      if (w_idx >= (PORT_W + 1)'(NUM_PORTS)) begin
        w_idx = w_idx - (PORT_W + 1)'(NUM_PORTS);
      end
      if (r_pending[w_idx[PORT_W-1:0]]) begin
        w_grant = w_idx[PORT_W-1:0];
      end
    end
  end

  always_comb begin
    w_load = (!r_valid || i_out_ready) && (|r_pending);
    w_move = w_load ? (NUM_PORTS'(1) << w_grant) : '0;
    // A slot that stays occupied this cycle cannot take a new capture.
    w_keep = r_pending & ~w_move;
    w_drop = i_cap_req & w_keep;

    w_ndrop = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_ndrop = w_ndrop + {4'b0, w_drop[p]};
    end
    w_cnt_sum  = (i_drop_clear ? '0 : SumW'(r_drop_cnt)) + SumW'(w_ndrop);
    w_cnt_next = (|w_cnt_sum[SumW-1:DROP_CNT_W]) ? '1 : w_cnt_sum[DROP_CNT_W-1:0];

    if (32'(w_grant) == NUM_PORTS - 1) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_grant + PORT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending   <= '0;
      r_ptr       <= '0;
      r_valid     <= 1'b0;
      r_port      <= '0;
      r_sec       <= '0;
      r_ns        <= '0;
      r_drop_flag <= '0;
      r_drop_cnt  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_slot_sec[p] <= '0;
        r_slot_ns[p]  <= '0;
      end
    end else begin
      r_pending   <= i_cap_req | w_keep;
      r_drop_flag <= (i_drop_clear ? '0 : r_drop_flag) | w_drop;
      r_drop_cnt  <= w_cnt_next;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (i_cap_req[p] && !w_keep[p]) begin
          r_slot_sec[p] <= i_ts_seconds;
          r_slot_ns[p]  <= i_ts_nanoseconds;
        end
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_port  <= w_grant;
        r_sec   <= r_slot_sec[w_grant];
        r_ns    <= r_slot_ns[w_grant];
        r_ptr   <= w_ptr_next;
      end else if (i_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid       = r_valid;
  assign o_out_port        = r_port;
  assign o_out_seconds     = r_sec;
  assign o_out_nanoseconds = r_ns;
  assign o_drop_flag       = r_drop_flag;
  assign o_drop_count      = r_drop_cnt;

endmodule

// File: tb/tb_ts_capture_arbiter.sv
// Bench for ts_capture_arbiter: transaction-level model checked every cycle, plus directed
// scenarios with literal expectations. A second instance uses a 2-bit drop counter.
module tb_ts_capture_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  ts_s, ts_ns;
  logic [N-1:0] cap;
  logic         rdy, clr;

  logic         a_valid, b_valid;
  logic [1:0]   a_port, b_port;
  logic [31:0]  a_sec, a_ns, b_sec, b_ns;
  logic [N-1:0] a_flag, b_flag;
  logic [15:0]  a_cnt;
  logic [1:0]   b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ts_capture_arbiter #(.NUM_PORTS(N)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .i_ts_seconds(ts_s), .i_ts_nanoseconds(ts_ns),
    .i_cap_req(cap), .o_out_valid(a_valid), .i_out_ready(rdy), .o_out_port(a_port),
    .o_out_seconds(a_sec), .o_out_nanoseconds(a_ns), .o_drop_flag(a_flag),
    .o_drop_count(a_cnt), .i_drop_clear(clr)
  );

  ts_capture_arbiter #(.NUM_PORTS(N), .DROP_CNT_W(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .i_ts_seconds(ts_s), .i_ts_nanoseconds(ts_ns),
    .i_cap_req(cap), .o_out_valid(b_valid), .i_out_ready(rdy), .o_out_port(b_port),
    .o_out_seconds(b_sec), .o_out_nanoseconds(b_ns), .o_drop_flag(b_flag),
    .o_drop_count(b_cnt), .i_drop_clear(clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-port holding slots, one output record, pointer, and uncapped drop total.
  bit          m_pend [N];
  logic [31:0] m_s [N];
  logic [31:0] m_n [N];
  int          m_ptr = 0;
  bit          m_valid = 0;
  int          m_port = 0;
  logic [31:0] m_os = '0, m_on = '0;
  logic [N-1:0] m_flag = '0;
  int          m_drops = 0;
  int          g, nd;
  bit          ld;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int p = 0; p < N; p++) begin
        m_pend[p] = 0;
        m_s[p] = '0;
        m_n[p] = '0;
      end
      m_ptr = 0; m_valid = 0; m_port = 0; m_os = '0; m_on = '0; m_flag = '0; m_drops = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      ld = (!m_valid || rdy) && (g >= 0);
      if (ld) begin
        m_valid = 1; m_port = g; m_os = m_s[g]; m_on = m_n[g];
        m_pend[g] = 0;
        m_ptr = (g + 1) % N;
      end else if (rdy) begin
        m_valid = 0;
      end
      if (clr) begin
        m_flag = '0;
        m_drops = 0;
      end
      nd = 0;
      for (int p = 0; p < N; p++) begin
        if (cap[p]) begin
          if (m_pend[p]) begin
            m_flag[p] = 1'b1;
            nd++;
          end else begin
            m_pend[p] = 1; m_s[p] = ts_s; m_n[p] = ts_ns;
          end
        end
      end
      m_drops += nd;
    end
  end

  always @(negedge clk) begin
    chk("m_valid", 64'(a_valid), 64'(m_valid));
    chk("m_port", 64'(a_port), 64'(m_port));
    chk("m_sec", 64'(a_sec), 64'(m_os));
    chk("m_ns", 64'(a_ns), 64'(m_on));
    chk("m_flag", 64'(a_flag), 64'(m_flag));
    chk("m_cnt", 64'(a_cnt), 64'((m_drops > 65535) ? 65535 : m_drops));
    chk("m_b_valid", 64'(b_valid), 64'(m_valid));
    chk("m_b_port", 64'(b_port), 64'(m_port));
    chk("m_b_ns", 64'(b_ns), 64'(m_on));
    chk("m_b_sec", 64'(b_sec), 64'(m_os));
    chk("m_b_flag", 64'(b_flag), 64'(m_flag));
    chk("m_b_cnt", 64'(b_cnt), 64'((m_drops > 3) ? 3 : m_drops));
  end

  task automatic step(input logic [31:0] s, input logic [31:0] ns, input logic [N-1:0] c,
                      input logic r, input logic cl = 1'b0);
    ts_s = s; ts_ns = ns; cap = c; rdy = r; clr = cl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(0, 0, '0, 1'b0);
    step(0, 0, '0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic chk_rec(input string name, input logic [1:0] port, input logic [31:0] s,
                         input logic [31:0] ns);
    chk({name, "_valid"}, 64'(a_valid), 64'(1));
    chk({name, "_port"}, 64'(a_port), 64'(port));
    chk({name, "_sec"}, 64'(a_sec), 64'(s));
    chk({name, "_ns"}, 64'(a_ns), 64'(ns));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, 64'(a_valid), 64'(0));
    chk({name, "_port"}, 64'(a_port), 64'(0));
    chk({name, "_sec"}, 64'(a_sec), 64'(0));
    chk({name, "_ns"}, 64'(a_ns), 64'(0));
    chk({name, "_flag"}, 64'(a_flag), 64'(0));
    chk({name, "_cnt"}, 64'(a_cnt), 64'(0));
    chk({name, "_b_cnt"}, 64'(b_cnt), 64'(0));
  endtask

  initial begin
    reset_n = 1'b0; ts_s = '0; ts_ns = '0; cap = '0; rdy = 1'b0; clr = 1'b0;
    @(negedge clk);
    do_reset();
    chk_zero("reset");

    // Single capture: valid at t+2, gone at t+3.
    step(5, 980, 4'b0001, 1'b1);
    chk("single_t1_valid", 64'(a_valid), 64'(0));
    step(6, 0, '0, 1'b1);
    chk_rec("single_t2", 2'd0, 5, 980);
    step(7, 0, '0, 1'b1);
    chk("single_t3_valid", 64'(a_valid), 64'(0));

    // All-port burst drained 0..3 back to back; pointer wraps to 0.
    do_reset();
    step(1, 40, 4'b1111, 1'b1);
    for (int k = 0; k < N; k++) begin
      step(2, 32'(k), '0, 1'b1);
      chk_rec("burst", 2'(k), 1, 40);
    end
    step(0, 0, '0, 1'b1);
    chk("burst_end_valid", 64'(a_valid), 64'(0));
    step(7, 7, 4'b1001, 1'b1);
    step(0, 0, '0, 1'b1);
    chk_rec("burst_ptr0", 2'd0, 7, 7);
    step(0, 0, '0, 1'b1);
    chk_rec("burst_ptr3", 2'd3, 7, 7);

    // Backpressure: port 2 held stable, then port 3 follows.
    do_reset();
    step(9, 9, 4'b1100, 1'b0);
    step(0, 0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk_rec("bp_hold", 2'd2, 9, 9);
      step(0, 0, '0, 1'b0);
    end
    chk_rec("bp_hold", 2'd2, 9, 9);
    step(0, 0, '0, 1'b1);
    chk_rec("bp_next", 2'd3, 9, 9);
    step(0, 0, '0, 1'b1);
    chk("bp_end_valid", 64'(a_valid), 64'(0));

    // Overflow on port 1: 200 fills the freed slot, 300 is dropped.
    do_reset();
    step(0, 50, 4'b0010, 1'b0);
    step(0, 60, '0, 1'b0);
    chk_rec("ovf_first", 2'd1, 0, 50);
    step(0, 100, 4'b0010, 1'b0);
    step(0, 200, 4'b0010, 1'b1);
    chk_rec("ovf_100", 2'd1, 0, 100);
    chk("ovf_200_nodrop", 64'(a_cnt), 64'(0));
    step(0, 300, 4'b0010, 1'b0);
    chk("ovf_flag", 64'(a_flag), 64'(4'b0010));
    chk("ovf_cnt", 64'(a_cnt), 64'(1));
    step(0, 0, '0, 1'b1);
    chk_rec("ovf_200", 2'd1, 0, 200);
    step(0, 0, '0, 1'b1);
    chk("ovf_drained", 64'(a_valid), 64'(0));
    chk("ovf_flag_held", 64'(a_flag), 64'(4'b0010));
    step(0, 0, '0, 1'b0, 1'b1);
    chk("clr_flag", 64'(a_flag), 64'(0));
    chk("clr_cnt", 64'(a_cnt), 64'(0));

    // Strobe while slot 3 moves out: accepted, emitted next.
    do_reset();
    step(3, 30, 4'b1000, 1'b0);
    step(3, 0, '0, 1'b0);
    step(3, 31, 4'b1000, 1'b0);
    step(3, 32, 4'b1000, 1'b1);
    chk_rec("move_31", 2'd3, 3, 31);
    step(0, 0, '0, 1'b1);
    chk_rec("move_32", 2'd3, 3, 32);
    chk("move_flag", 64'(a_flag), 64'(0));
    chk("move_cnt", 64'(a_cnt), 64'(0));

    // Saturation: five drops on port 0.
    do_reset();
    step(0, 1, 4'b0001, 1'b0);
    step(0, 2, 4'b0001, 1'b0);
    for (int k = 0; k < 5; k++) step(0, 32'(10 + k), 4'b0001, 1'b0);
    chk("sat_cnt16", 64'(a_cnt), 64'(5));
    chk("sat_cnt2", 64'(b_cnt), 64'(3));
    chk("sat_flag", 64'(b_flag), 64'(4'b0001));
    chk_rec("sat_rec", 2'd0, 0, 1);

    // Reset in the middle of a burst leaves nothing behind.
    step(4, 4, 4'b1111, 1'b1);
    reset_n = 1'b0;
    step(5, 5, 4'b1111, 1'b1);
    step(5, 5, 4'b1111, 1'b1);
    chk_zero("mid_reset");
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, '0, 1'b1);
      chk("post_reset_valid", 64'(a_valid), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ts_capture_arbiter.md
Name: ts_capture_arbiter

Overview:
- Shares the free-running seconds/nanoseconds timestamp between NUM_PORTS capture requesters, such as per-interface start-of-frame strobes in the capture path.
- Latches the timestamp in the exact cycle each strobe fires, one holding slot per port.
- Drains pending slots round-robin into one valid/ready stream tagged with the port id.
- Counts and flags captures lost because a slot was still occupied.

Parameters:
NUM_PORTS, 4, number of capture requesters (2..16)
DROP_CNT_W, 16, width of saturating drop counter
PORT_W, $clog2(NUM_PORTS) (min 1), derived: width of port id

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
ts_seconds  in  32  seconds from timestamp counter
ts_nanoseconds  in  32  nanoseconds from timestamp counter
cap_req  in  NUM_PORTS  single-cycle capture strobe per port
out_valid  out  1  captured record available
out_ready  in  1  downstream accepts record
out_port  out  PORT_W  port that issued the capture
out_seconds  out  32  captured seconds
out_nanoseconds  out  32  captured nanoseconds
drop_flag  out  NUM_PORTS  sticky per-port overflow flag
drop_count  out  DROP_CNT_W  saturating total of dropped captures
drop_clear  in  1  clears drop_flag and drop_count

Behaviour:
- Reset: all outputs are 0, all slots are empty, and the RR pointer is 0. Reset takes priority over every other input. A reset asserted mid-transfer discards slots and the output register with no partial record.
- Capture: when cap_req[p]=1 in cycle t, slot p stores the ts_seconds/ts_nanoseconds values present in cycle t and pending[p]=1 from t+1.
- Slot free condition for port p: pending[p]=0, or slot p is moved into the output register in the same cycle. In that case the new capture is accepted with no drop.
- Drop: cap_req[p]=1 while slot p is occupied and not moving out. The new timestamp is discarded and the old one kept. drop_flag[p] is set. drop_count is incremented by the number of ports dropping this cycle and saturates at all-ones.
- drop_clear: zeroes drop_flag and drop_count. A drop in the same cycle wins: the flag is set and the count restarts from the number dropped that cycle.
- Output register load: happens when (out_valid=0 or out_valid&&out_ready) and any pending bit is set.
  - Grant goes to the first pending port at or after the RR pointer, wrapping modulo NUM_PORTS.
  - The granted slot moves to the output register and its pending bit clears.
  - The RR pointer becomes grant+1 mod NUM_PORTS. The pointer is unchanged when there is no grant.
- If out_valid&&out_ready and nothing is pending, out_valid drops to 0 next cycle. Data fields hold their last value.
- Stream rules: while out_valid=1 and out_ready=0, out_port/out_seconds/out_nanoseconds are stable. out_valid does not depend combinationally on out_ready.
- Latency: strobe in cycle t gives out_valid=1 in cycle t+2 when the output is idle and no other port is pending.
- Throughput: one record per cycle under continuous out_ready=1.
- Simultaneous strobes on all ports are all captured with the same timestamp and drained in RR order.
- The timestamp inputs are used as-is; seconds rollover needs no special handling.

Test Plan:
- Single capture: ts=(5 s, 980 ns), cap_req=0001 at cycle t, out_ready=1 -> out_valid at t+2 with port 0, 5 s, 980 ns. out_valid is low at t+3.
- All-port burst: cap_req=1111 at ts=(1 s, 40 ns), pointer=0, out_ready=1 -> records for ports 0,1,2,3 on consecutive cycles, all (1, 40). The pointer ends at 0.
- Backpressure: out_ready=0 for 5 cycles with record (port 2) valid -> out_valid and fields are stable throughout. Release -> transfer, then the next pending port follows in RR order.
- Overflow:
  - Port 1 captures at 100 ns while the output register is stalled with an earlier port-1 record.
  - Port 1 strobes again at 200 ns and then at 300 ns.
  - Expected: the 200 ns capture fills the now-free slot; the 300 ns capture is dropped.
  - Expected: drop_flag[1]=1, drop_count=1; the records emitted are 100 and 200.
  - drop_clear -> flag and count return to 0.
- Strobe in the cycle slot 3 moves to the output register -> no drop, and the new timestamp is emitted next.
- Saturation: with DROP_CNT_W=2, force 5 drops -> drop_count=3. Reset mid-burst -> outputs are 0, no stale records after release.
